// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-register chain.
//   MAX_STAGES : largest supported chain depth.
//   cnt_w()    : occupancy counter width for a given depth and skid option.
//                The counter must represent 0 .. stages*(1+skid) inclusive.
package pipe_pkg;

  localparam int MAX_STAGES = 8;

  function automatic int cnt_w(input int stages, input int skid);
    return $clog2(stages * ((skid != 0) ? 2 : 1) + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a main slot and, when SKID=1, a skid slot.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   flush               kill everything this stage holds after this edge
//   in_valid/in_data    upstream item, in_ready = this stage accepts it
//   out_valid/out_data  main slot contents, out_ready = downstream takes it
//   fill_nxt            number of valid slots this stage will hold after the edge
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        fill_nxt
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t main_q, main_d;
  logic  push, pop;

  assign out_valid = main_q.valid;
  assign out_data  = main_q.data;
  assign push      = in_valid && in_ready;
  assign pop       = main_q.valid && out_ready;

  if (SKID != 0) begin : g_skid
    slot_t skid_q, skid_d;

    // Ready depends only on the skid register, so out_ready never reaches in_ready
    assign in_ready = !skid_q.valid;

    always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (!main_q.valid || pop) begin
        // Main slot frees up: the older skid item has priority over a new push.
        // A push can't coincide with a full skid because in_ready is low then.
        if (skid_q.valid) begin
          main_d       = skid_q;
          skid_d.valid = 1'b0;
        end else if (push) begin
          main_d.valid = 1'b1;
          main_d.data  = in_data;
        end else begin
          main_d.valid = 1'b0;
        end
      end else if (push) begin
        skid_d.valid = 1'b1;
        skid_d.data  = in_data;
      end
      // Flush beats any load; data regs keep their previous value
      if (flush) begin
        main_d.valid = 1'b0;
        main_d.data  = main_q.data;
        skid_d.valid = 1'b0;
        skid_d.data  = skid_q.data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) skid_q <= '0;
      else      skid_q <= skid_d;
    end

    assign fill_nxt = {1'b0, main_d.valid} + {1'b0, skid_d.valid};
  end else begin : g_noskid
    assign in_ready = !main_q.valid || out_ready;

    always_comb begin
      main_d = main_q;
      if (push) begin
        main_d.valid = 1'b1;
        main_d.data  = in_data;
      end else if (pop) begin
        main_d.valid = 1'b0;
      end
      if (flush) begin
        main_d.valid = 1'b0;
        main_d.data  = main_q.data;
      end
    end

    assign fill_nxt = {1'b0, main_d.valid};
  end

  always_ff @(posedge clk) begin
    if (!rst) main_q <= '0;
    else      main_q <= main_d;
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised elastic pipeline-register chain with per-stage flush and
// optional skid buffering; reports occupancy to the hazard logic.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_data    upstream item, in_ready = chain accepts it this cycle
//   out_valid/out_data  last-stage item, out_ready = downstream takes it
//   flush[k]            kill stage k contents (bit 0 = first stage)
//   occupancy           registered count of valid items incl. skid slots
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 3,
  parameter int SKID   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [DATA_W-1:0]                 out_data,
  input  logic                              out_ready,
  input  logic [STAGES-1:0]                 flush,
  output logic [cnt_w(STAGES, SKID)-1:0]    occupancy
);

  localparam int CNT_W = cnt_w(STAGES, SKID);

  logic [CNT_W-1:0] occ_nxt;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              up_valid;
    logic [DATA_W-1:0] up_data;
    logic              up_ready;
    logic              dn_valid;
    logic [DATA_W-1:0] dn_data;
    logic              dn_ready;
    logic [1:0]        fill;
    logic [CNT_W-1:0]  occ_acc;

    pipe_stage #(
      .DATA_W (DATA_W),
      .SKID   (SKID)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[k]),
      .in_valid  (up_valid),
      .in_data   (up_data),
      .in_ready  (up_ready),
      .out_valid (dn_valid),
      .out_data  (dn_data),
      .out_ready (dn_ready),
      .fill_nxt  (fill)
    );

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign occ_acc  = CNT_W'(fill);
    end else begin : g_link
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
      assign occ_acc  = g_stage[k-1].occ_acc + CNT_W'(fill);
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[k+1].up_ready;
    end
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[STAGES-1].dn_valid;
  assign out_data  = g_stage[STAGES-1].dn_data;
  assign occ_nxt   = g_stage[STAGES-1].occ_acc;

  // Summing next-state slot valids keeps the count exact under flush,
  // including items discarded on entry, without a separate kill tally.
  always_ff @(posedge clk) begin
    if (!rst) occupancy <= '0;
    else      occupancy <= occ_nxt;
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  localparam int STAGES = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic [2:0]  flush;
  int          cur;

  logic        iv0, iv1, or0, or1, ir0, ir1, ov0, ov1;
  logic [63:0] od0, od1;
  logic [2:0]  fl0, fl1;
  logic [1:0]  occ0;
  logic [2:0]  occ1;

  assign iv0 = in_valid && (cur == 0);
  assign iv1 = in_valid && (cur == 1);
  assign or0 = (cur == 0) ? out_ready : 1'b1;
  assign or1 = (cur == 1) ? out_ready : 1'b1;
  assign fl0 = (cur == 0) ? flush : 3'b000;
  assign fl1 = (cur == 1) ? flush : 3'b000;

  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [2:0]  occ;
  assign in_ready  = (cur == 1) ? ir1 : ir0;
  assign out_valid = (cur == 1) ? ov1 : ov0;
  assign out_data  = (cur == 1) ? od1 : od0;
  assign occ       = (cur == 1) ? occ1 : {1'b0, occ0};

  pipe_stage_chain #(.DATA_W(64), .STAGES(STAGES), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_data(in_data), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(or0), .flush(fl0), .occupancy(occ0));

  pipe_stage_chain #(.DATA_W(64), .STAGES(STAGES), .SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_data(in_data), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(or1), .flush(fl1), .occupancy(occ1));

  int          n_assert;
  int          n_fail;
  logic [63:0] sb[$];
  logic        last_acc;
  logic        last_ir;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (skid=%0d): got %0h expected %0h", tag, cur, act, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge
  task automatic tick(input bit kill_in, input int kill_idx);
    logic        pop, hold, ir_now;
    logic [63:0] held;
    #2;
    if (cur == 1) begin
      ir_now    = in_ready;
      out_ready = ~out_ready;
      #1;
      check_eq("ready_comb_path", 64'(in_ready), 64'(ir_now));
      out_ready = ~out_ready;
      #1;
    end else begin
      #2;
    end
    last_ir  = in_ready;
    last_acc = in_valid && in_ready;
    pop      = out_valid && out_ready;
    hold     = out_valid && !out_ready && !flush[STAGES-1];
    held     = out_data;
    if (pop) begin
      if (sb.size() == 0) check_eq("spurious_out", 64'(out_valid), 64'd0);
      else                check_eq("out_data", out_data, sb.pop_front());
    end
    if (last_acc && !kill_in) sb.push_back(in_data);
    if (kill_idx >= 0 && kill_idx < sb.size()) sb.delete(kill_idx);
    @(posedge clk);
    #1;
    check_eq("occupancy", 64'(occ), 64'(sb.size()));
    if (hold) begin
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_hold", out_data, held);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; in_valid = 1'b0; flush = 3'b000; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_occupancy", 64'(occ), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; flush = 3'b000; out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 30) begin
      tick(1'b0, -1);
      n++;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
    check_eq("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic run_all();
    int first_out, idx, peak, guard;
    logic taken;
    do_reset(2);

    // Unobstructed stream: latency STAGES-1 edges after acceptance
    first_out = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      in_data = 64'(c);
      tick(1'b0, -1);
      if (out_valid && first_out < 0) first_out = c;
    end
    check_eq("t1_latency", 64'(first_out), 64'(STAGES));
    check_eq("t1_steady_occ", 64'(occ), 64'(STAGES));
    drain();

    // Four-cycle stall mid-stream
    idx  = 0;
    peak = 0;
    for (int c = 1; c <= 40 && idx < 10; c++) begin
      in_valid  = 1'b1;
      in_data   = 64'hA0 + 64'(idx);
      out_ready = !(c >= 5 && c <= 8);
      tick(1'b0, -1);
      if (last_acc) idx++;
      if (int'(occ) > peak) peak = int'(occ);
    end
    check_eq("t2_accepted", 64'(idx), 64'd10);
    check_eq("t2_peak_occ", 64'(peak), (cur == 1) ? 64'd6 : 64'd3);
    drain();

    // Flush middle stage of a full, stalled chain while offering 0xB4.
    // No skid: stage 2 stalls so 0xB2 sits in stage 1 and dies; 0xB4 waits.
    // Skid: 0xB2 escapes into stage 2's skid, 0xB3 entering stage 1 dies.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hB1 + 64'(i);
      tick(1'b0, -1);
    end
    check_eq("t3_full_occ", 64'(occ), 64'd3);
    in_data = 64'hB4;
    flush   = 3'b010;
    tick(1'b0, (cur == 1) ? 2 : 1);
    flush = 3'b000;
    taken = last_acc;
    check_eq("t3_flush_in_ready", 64'(last_ir), 64'(cur == 1));
    check_eq("t3_occ_after_flush", 64'(occ), (cur == 1) ? 64'd3 : 64'd2);
    out_ready = 1'b1;
    guard = 0;
    while (!taken && guard < 10) begin
      tick(1'b0, -1);
      taken = last_acc;
      guard++;
    end
    check_eq("t3_b4_taken", 64'(taken), 64'd1);
    drain();

    // Flush first stage as 0xC5 enters while 0xC4 moves on
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hC4;
    tick(1'b0, -1);
    in_data = 64'hC5;
    flush   = 3'b001;
    tick(1'b1, -1);
    flush = 3'b000;
    check_eq("t4_in_ready_flush", 64'(last_ir), 64'd1);
    check_eq("t4_occ_after_flush", 64'(occ), 64'd1);
    in_valid = 1'b0;
    tick(1'b0, -1);
    check_eq("t4_in_ready_after", 64'(in_ready), 64'd1);
    drain();

    // Reset with items in flight, then resume
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hD0 + 64'(i);
      tick(1'b0, -1);
    end
    check_eq("t5_inflight", 64'(occ), (cur == 1) ? 64'd5 : 64'd3);
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'hE0 + 64'(i);
      tick(1'b0, -1);
    end
    drain();

    // Random valid/ready traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick(1'b0, -1);
    end
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expired, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    cur       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    flush     = 3'b000;
    for (int u = 0; u < 2; u++) begin
      cur = u;
      run_all();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
